// File: rtl/fxp_div_pkg.sv
// Shared types and helpers for the sequential fixed-point divider.
package fxp_div_pkg;

    // Controller states: waiting for operands, iterating, holding a result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of bits needed to encode values 0 .. value-1.
    function automatic int clog2(input int value);
        int bits;
        int rest;
        bits = 0;
        rest = value - 1;
        while (rest > 0) begin
            bits = bits + 1;
            rest = rest >> 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/fxp_div_step.sv
// One restoring-division step: shift in the next numerator bit, subtract
// the divisor when it fits, and report the resulting quotient bit.
module fxp_div_step #(
    parameter int N2 = 16
) (
    input  logic [N2-1:0] rem,
    input  logic          bit_in,
    input  logic [N2-1:0] dvs,
    output logic [N2-1:0] rem_next,
    output logic          q_bit
);

    logic [N2:0] shifted;

    // Trial subtraction; the remainder stays below twice the divisor, so N2 bits hold it.
    always_comb begin
        shifted  = {rem, bit_in};
        q_bit    = (shifted >= {1'b0, dvs});
        rem_next = q_bit ? (shifted[N2-1:0] - dvs) : shifted[N2-1:0];
    end

endmodule

// File: rtl/fxp_div_seq.sv
// Sequential sign-magnitude fixed-point divider, one quotient bit per clock.
// quotient = (|dvd| << FRAC_SH) / |dvs|, scaled to N_RES bits with
// saturation. Define FXP_DIV_ROUND_EN for round-to-nearest (ties away from
// zero); otherwise the quotient is truncated toward zero.
// The numerator width N1-1+FRAC_SH must exceed the result magnitude width.
module fxp_div_seq
    import fxp_div_pkg::*;
#(
    parameter int N1      = 32,
    parameter int N2      = 16,
    parameter int N_RES   = 32,
    parameter int FRAC_SH = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N1-1:0]    dvd,
    input  logic [N2-1:0]    dvs,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N_RES-1:0] result,
    output logic             ovr,
    output logic             dz
);

    localparam int W  = N1 - 1 + FRAC_SH;
    localparam int Q  = N_RES - 1;
    localparam int CW = clog2(W + 1);

    state_t        state, state_next;
    logic [W-1:0]  num;
    logic [W-2:0]  quo;
    logic [N2-1:0] rem;
    logic [N2-1:0] dvs_mag;
    logic [CW-1:0] cnt;
    logic          sign;

    logic          accept;
    logic          dvs_zero;
    logic [N2-1:0] rem_next;
    logic          q_bit;
    logic [W-1:0]  quo_next;
    logic          over;
    logic [Q-1:0]  mag_final;
    logic          ovr_final;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid & in_ready;
    assign dvs_zero  = (dvs[N2-2:0] == '0);

    fxp_div_step #(.N2(N2)) u_step (
        .rem      (rem),
        .bit_in   (num[W-1]),
        .dvs      (dvs_mag),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    // Final magnitude and overflow flag, valid during the last BUSY cycle.
    always_comb begin
        quo_next = {quo, q_bit};
        over     = |quo_next[W-1:Q];
`ifdef FXP_DIV_ROUND_EN
        begin : round_blk
            logic         round_up;
            logic [Q:0]   mag_sum;
            round_up  = ({rem_next, 1'b0} >= {1'b0, dvs_mag});
            mag_sum   = {1'b0, quo_next[Q-1:0]} + {{Q{1'b0}}, round_up};
            ovr_final = over | mag_sum[Q];
            mag_final = ovr_final ? {Q{1'b1}} : mag_sum[Q-1:0];
        end
`else
        ovr_final = over;
        mag_final = over ? {Q{1'b1}} : quo_next[Q-1:0];
`endif
    end

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic.
    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = dvs_zero ? DONE : BUSY;
            BUSY:    if (cnt == CW'(1)) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: operand capture, iteration registers and the held result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num     <= '0;
            quo     <= '0;
            rem     <= '0;
            dvs_mag <= '0;
            cnt     <= '0;
            sign    <= 1'b0;
            result  <= '0;
            ovr     <= 1'b0;
            dz      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        num     <= {dvd[N1-2:0], {FRAC_SH{1'b0}}};
                        dvs_mag <= {1'b0, dvs[N2-2:0]};
                        sign    <= dvd[N1-1] ^ dvs[N2-1];
                        rem     <= '0;
                        quo     <= '0;
                        cnt     <= CW'(W);
                        if (dvs_zero) begin
                            result <= {dvd[N1-1] ^ dvs[N2-1], {Q{1'b1}}};
                            ovr    <= 1'b1;
                            dz     <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    num <= num << 1;
                    rem <= rem_next;
                    quo <= quo_next[W-2:0];
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        result <= {sign & (|mag_final), mag_final};
                        ovr    <= ovr_final;
                        dz     <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
